// File: rtl/pc_sequencer_pkg.sv
// Shared types for the RV32I PC sequencer.
// State and trap-cause encodings, branch funct3 codes, target helper.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10,
        TRAP  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        MISALIGN = 2'b01,
        TIMEOUT  = 2'b10,
        ILLEGAL  = 2'b11
    } cause_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // JALR drops bit 0 of the computed address; other targets pass through.
    function automatic logic [31:0] jump_target(
        input logic [31:0] a,
        input logic        is_jalr
    );
        return is_jalr ? {a[31:1], 1'b0} : a;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and the rest of the core.
// master = sequencer side, slave = datapath / imem side.
interface pc_sequencer_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        instr_valid;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] alu_result;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        next_pc_src;
    logic [31:0] next_pc;
    logic        trap;
    logic [1:0]  trap_cause;
    logic        halted;
    logic [31:0] instret;

    modport master (
        output imem_req, imem_addr, instr_valid,
        output pc, pc_plus4, next_pc_src, next_pc,
        output trap, trap_cause, halted, instret,
        input  imem_ready, stall, branch, jump, jalr,
        input  funct3, zero, lt, ltu, alu_result, halt_req
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid,
        input  pc, pc_plus4, next_pc_src, next_pc,
        input  trap, trap_cause, halted, instret,
        output imem_ready, stall, branch, jump, jalr,
        output funct3, zero, lt, ltu, alu_result, halt_req
    );

endinterface

// File: rtl/pc_sequencer_branch_cond.sv
// Branch condition evaluation from funct3 and ALU flags.
// Flags the two funct3 codes that are not valid branches.
module branch_cond
    import pc_seq_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_cond,
    output logic       o_illegal
);

    // Decode funct3 into the branch condition; 010/011 are illegal.
    always_comb begin
        o_cond    = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_cond = i_zero;
            F3_BNE:  o_cond = ~i_zero;
            F3_BLT:  o_cond = i_lt;
            F3_BGE:  o_cond = ~i_lt;
            F3_BLTU: o_cond = i_ltu;
            F3_BGEU: o_cond = ~i_ltu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch handshake and next-PC resolution for RV32I.
// Misaligned targets, illegal branches and fetch timeouts trap stickily.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16,
    parameter int          CNT_W        = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    localparam bit              LP_TO_EN   = (IMEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    state_e           r_state;
    cause_e           r_cause;
    logic [31:0]      r_pc;
    logic [31:0]      r_instret;
    logic [CNT_W-1:0] r_cnt;

    logic        w_cond;
    logic        w_illegal_f3;
    logic        w_bad_branch;
    logic        w_taken;
    logic        w_misalign;
    logic        w_in_exec;
    logic        w_timeout_hit;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_next_src;

    branch_cond u_branch_cond (
        .i_funct3  (bus.funct3),
        .i_zero    (bus.zero),
        .i_lt      (bus.lt),
        .i_ltu     (bus.ltu),
        .o_cond    (w_cond),
        .o_illegal (w_illegal_f3)
    );

    assign w_in_exec     = (r_state == EXEC);
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_target      = jump_target(bus.alu_result, bus.jalr);
    assign w_taken       = bus.jump | (bus.branch & w_cond);
    assign w_bad_branch  = bus.branch & w_illegal_f3;
    assign w_misalign    = w_taken & w_target[1];
    assign w_next_src    = w_in_exec & w_taken;
    assign w_next_pc     = w_next_src ? w_target : w_pc_plus4;
    assign w_timeout_hit = LP_TO_EN && (r_cnt == LP_CNT_LAST);

    // imem_req is gated by rst_n so it drops during a reset cycle.
    assign bus.imem_req    = rst_n & (r_state == FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = w_in_exec;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.next_pc_src = w_next_src;
    assign bus.next_pc     = w_next_pc;
    assign bus.trap        = (r_state == TRAP);
    assign bus.trap_cause  = r_cause;
    assign bus.halted      = (r_state == HALT);
    assign bus.instret     = r_instret;

    // Sequencer FSM: fetch, execute/commit, and the absorbing halt/trap states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_cause   <= NONE;
            r_pc      <= RESET_VEC;
            r_instret <= 32'd0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (bus.imem_ready) begin
                        r_state <= EXEC;
                    end else if (w_timeout_hit) begin
                        r_state <= TRAP;
                        r_cause <= TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                EXEC: begin
                    if (bus.stall) begin
                        r_state <= EXEC;
                    end else if (bus.halt_req) begin
                        r_state   <= HALT;
                        r_instret <= r_instret + 32'd1;
                    end else if (w_bad_branch) begin
                        r_state <= TRAP;
                        r_cause <= ILLEGAL;
                    end else if (w_misalign) begin
                        r_state <= TRAP;
                        r_cause <= MISALIGN;
                    end else begin
                        r_state   <= FETCH;
                        r_pc      <= w_next_pc;
                        r_instret <= r_instret + 32'd1;
                        r_cnt     <= '0;
                    end
                end
                HALT: r_state <= HALT;
                TRAP: r_state <= TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed steps then random
// episodes, compared each cycle against a behavioural model.
module tb_pc_sequencer;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VEC    (32'h0000_0000),
        .IMEM_TIMEOUT (TO),
        .CNT_W        (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum {M_FETCH, M_EXEC, M_HALT, M_TRAP} mmode_e;
    mmode_e      m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic [1:0]  m_cause;
    int          m_wait;

    function automatic logic [31:0] m_tgt();
        if (bus.jalr)
            return bus.alu_result & 32'hFFFF_FFFE;
        return bus.alu_result;
    endfunction

    function automatic bit m_taken();
        if (bus.jump) return 1'b1;
        if (!bus.branch) return 1'b0;
        case (bus.funct3)
            3'd0: return bus.zero;
            3'd1: return !bus.zero;
            3'd4: return bus.lt;
            3'd5: return !bus.lt;
            3'd6: return bus.ltu;
            3'd7: return !bus.ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        m_mode  = M_FETCH;
        m_pc    = 32'h0;
        m_ret   = 32'h0;
        m_cause = 2'b00;
        m_wait  = 0;
    endtask

    task automatic model_adv();
        bit          tk;
        logic [31:0] t;
        if (!rst_n) begin
            m_reset();
            return;
        end
        case (m_mode)
            M_FETCH: begin
                if (bus.imem_ready) m_mode = M_EXEC;
                else if (m_wait == TO - 1) begin
                    m_mode = M_TRAP;
                    m_cause = 2'b10;
                end else m_wait++;
            end
            M_EXEC: begin
                tk = m_taken();
                t  = m_tgt();
                if (bus.stall) begin
                end else if (bus.halt_req) begin
                    m_mode = M_HALT;
                    m_ret++;
                end else if (bus.branch &&
                             (bus.funct3 == 3'd2 || bus.funct3 == 3'd3)) begin
                    m_mode = M_TRAP;
                    m_cause = 2'b11;
                end else if (tk && t[1]) begin
                    m_mode = M_TRAP;
                    m_cause = 2'b01;
                end else begin
                    m_pc   = tk ? t : m_pc + 32'd4;
                    m_ret++;
                    m_mode = M_FETCH;
                    m_wait = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          ex;
        bit          src;
        logic [31:0] nxt;
        ex  = (m_mode == M_EXEC);
        src = ex && m_taken();
        nxt = src ? m_tgt() : m_pc + 32'd4;
        chk("imem_req", 32'(bus.imem_req),
            32'(rst_n && m_mode == M_FETCH));
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr_valid", 32'(bus.instr_valid), 32'(ex));
        chk("pc", bus.pc, m_pc);
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        chk("next_pc_src", 32'(bus.next_pc_src), 32'(src));
        chk("next_pc", bus.next_pc, nxt);
        chk("trap", 32'(bus.trap), 32'(m_mode == M_TRAP));
        chk("trap_cause", 32'(bus.trap_cause), 32'(m_cause));
        chk("halted", 32'(bus.halted), 32'(m_mode == M_HALT));
        chk("instret", bus.instret, m_ret);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_adv();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.imem_ready = 1'b0;
        bus.stall      = 1'b0;
        bus.branch     = 1'b0;
        bus.jump       = 1'b0;
        bus.jalr       = 1'b0;
        bus.funct3     = 3'd0;
        bus.zero       = 1'b0;
        bus.lt         = 1'b0;
        bus.ltu        = 1'b0;
        bus.alu_result = 32'h0;
        bus.halt_req   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
    endtask

    task automatic fetch();
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
    endtask

    task automatic goto8();
        do_reset();
        repeat (2) begin
            fetch();
            step();
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        step();
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            chk("t1_pc", bus.pc, 32'(i * 4));
            fetch();
            step();
        end
        chk("t1_instret", bus.instret, 32'd4);

        // BNE taken / not taken
        goto8();
        fetch();
        bus.branch = 1'b1;
        bus.funct3 = 3'b001;
        bus.alu_result = 32'h40;
        #1;
        chk("t2_src", 32'(bus.next_pc_src), 32'd1);
        chk("t2_next", bus.next_pc, 32'h40);
        step();
        idle();
        chk("t2_pc", bus.pc, 32'h40);
        goto8();
        fetch();
        bus.branch = 1'b1;
        bus.funct3 = 3'b001;
        bus.zero = 1'b1;
        bus.alu_result = 32'h40;
        step();
        idle();
        chk("t2_nt_pc", bus.pc, 32'hC);

        // JALR bit-0 clear, then misaligned target
        do_reset();
        fetch();
        bus.jump = 1'b1;
        bus.jalr = 1'b1;
        bus.alu_result = 32'h101;
        step();
        idle();
        chk("t3_pc", bus.pc, 32'h100);
        fetch();
        bus.jump = 1'b1;
        bus.jalr = 1'b1;
        bus.alu_result = 32'h102;
        step();
        idle();
        chk("t3_trap", 32'(bus.trap), 32'd1);
        chk("t3_cause", 32'(bus.trap_cause), 32'd1);
        chk("t3_pc_hold", bus.pc, 32'h100);
        repeat (3) begin
            bus.imem_ready = 1'b1;
            step();
            chk("t3_req", 32'(bus.imem_req), 32'd0);
        end

        // Fetch timeout and last-cycle ready
        do_reset();
        repeat (TO - 1) step();
        chk("t4_pre", 32'(bus.trap), 32'd0);
        step();
        chk("t4_trap", 32'(bus.trap), 32'd1);
        chk("t4_cause", 32'(bus.trap_cause), 32'd2);
        do_reset();
        repeat (TO - 1) step();
        bus.imem_ready = 1'b1;
        step();
        idle();
        chk("t4_exec", 32'(bus.instr_valid), 32'd1);
        chk("t4_notrap", 32'(bus.trap), 32'd0);

        // Stall dominates halt, then halt retires
        do_reset();
        fetch();
        bus.stall = 1'b1;
        bus.halt_req = 1'b1;
        repeat (3) begin
            step();
            chk("t5_pc", bus.pc, 32'h0);
            chk("t5_ret", bus.instret, 32'd0);
        end
        bus.stall = 1'b0;
        step();
        idle();
        chk("t5_halted", 32'(bus.halted), 32'd1);
        chk("t5_ret1", bus.instret, 32'd1);

        // Reset mid-fetch
        do_reset();
        fetch();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_req_low", 32'(bus.imem_req), 32'd0);
        step();
        chk("t6_pc", bus.pc, 32'h0);
        chk("t6_ret", bus.instret, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("t6_req_hi", 32'(bus.imem_req), 32'd1);
        fetch();
        step();
        chk("t6_pc4", bus.pc, 32'h4);

        // PC wrap, jump dominating branch, illegal funct3
        do_reset();
        fetch();
        bus.jump = 1'b1;
        bus.alu_result = 32'hFFFF_FFFC;
        step();
        idle();
        fetch();
        #1;
        chk("wrap_next", bus.next_pc, 32'h0);
        step();
        chk("wrap_pc", bus.pc, 32'h0);
        chk("wrap_trap", 32'(bus.trap), 32'd0);
        fetch();
        bus.branch = 1'b1;
        bus.jump = 1'b1;
        bus.alu_result = 32'h20;
        #1;
        chk("bj_src", 32'(bus.next_pc_src), 32'd1);
        step();
        idle();
        chk("bj_pc", bus.pc, 32'h20);
        fetch();
        bus.branch = 1'b1;
        bus.funct3 = 3'b010;
        step();
        idle();
        chk("ill_cause", 32'(bus.trap_cause), 32'd3);

        // Random episodes
        for (int ep = 0; ep < 40; ep++) begin
            do_reset();
            for (int c = 0; c < 50; c++) begin
                bus.imem_ready = ($urandom_range(0, 9) < 6);
                bus.stall      = ($urandom_range(0, 9) < 2);
                bus.halt_req   = ($urandom_range(0, 29) == 0);
                bus.branch     = ($urandom_range(0, 9) < 4);
                bus.jump       = ($urandom_range(0, 9) < 2);
                bus.jalr       = $urandom_range(0, 1) == 1;
                bus.funct3     = 3'($urandom_range(0, 7));
                bus.zero       = $urandom_range(0, 1) == 1;
                bus.lt         = $urandom_range(0, 1) == 1;
                bus.ltu        = $urandom_range(0, 1) == 1;
                bus.alu_result = $urandom;
                if ($urandom_range(0, 1) == 1)
                    bus.alu_result[1:0] = 2'b00;
                rst_n = ($urandom_range(0, 49) != 0);
                step();
            end
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-sequencing controller for the RV32I core. Owns the PC register and the instruction-memory fetch handshake.
- Resolves branch/jump decisions into the select and target that the next-PC mux uses (next_pc_src, next_pc).
- Commits the new PC once per retired instruction.
- Detects misaligned targets, illegal branch encodings and fetch timeouts. Each of these enters a sticky trap state.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
IMEM_TIMEOUT, 16, max cycles in FETCH without imem_ready before trap; 0 disables timeout
CNT_W, 5, width of timeout counter (must hold IMEM_TIMEOUT-1)

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active-low
imem_req  out  1  fetch request, held high while in FETCH
imem_addr  out  32  fetch address (equals pc)
imem_ready  in  1  instruction word available this cycle
instr_valid  out  1  high in EXEC: datapath may execute/write back
stall  in  1  datapath not ready to retire (e.g. load wait)
branch  in  1  decoded conditional branch
jump  in  1  decoded JAL/JALR
jalr  in  1  decoded JALR (qualifies jump)
funct3  in  3  branch funct3
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
alu_result  in  32  computed branch/jump target
halt_req  in  1  ECALL/EBREAK decoded
pc  out  32  current PC
pc_plus4  out  32  pc + 4, modulo 2^32
next_pc_src  out  1  0 = pc_plus4, 1 = target
next_pc  out  32  selected next PC
trap  out  1  sticky trap flag
trap_cause  out  2  cause code, valid while trap = 1
halted  out  1  sticky halt flag
instret  out  32  retired-instruction count, wraps

Behaviour:
Reset state (rst_n low at a rising edge):
- pc=RESET_VEC; state=FETCH; imem_req=0 during reset; trap=0; trap_cause=0; halted=0; instret=0; timeout counter=0.
- A reset asserted mid-fetch or mid-EXEC aborts that fetch or instruction.
- imem_req is low in the cycle after the reset edge while rst_n is low, then rises on the first cycle with rst_n high.

States: FETCH, EXEC, HALT, TRAP.

FETCH:
- imem_req=1, imem_addr=pc.
- imem_ready=1 -> EXEC next cycle.
- The timeout counter increments each FETCH cycle without ready. It clears on entry to FETCH.
- Counter == IMEM_TIMEOUT-1 with no ready -> TRAP, cause TIMEOUT. Ready in that same cycle wins.

EXEC:
- instr_valid=1. imem_ready is ignored.
- Priority order: stall > halt_req > trap check > commit.
- stall=1: remain in EXEC; pc and instret hold.
- halt_req=1: go to HALT; pc holds; instret increments.
- branch=1 with funct3 in {010, 011}: go to TRAP, cause ILLEGAL.
- taken: taken = jump | (branch & cond).
  - BEQ: cond = zero. BNE: cond = !zero.
  - BLT: cond = lt. BGE: cond = !lt.
  - BLTU: cond = ltu. BGEU: cond = !ltu.
- Target: alu_result with bit 0 cleared when jalr=1; alu_result otherwise.
- taken and target[1] = 1: go to TRAP, cause MISALIGN; pc holds.
- Otherwise commit: pc <= next_pc; instret += 1; go to FETCH.

Combinational outputs:
- next_pc_src = taken, evaluated only in EXEC; 0 in all other states.
- next_pc = next_pc_src ? target : pc_plus4.

HALT and TRAP:
- Both are absorbing until reset. imem_req=0 and instr_valid=0.
- halted=1 in HALT. trap=1 with the latched trap_cause in TRAP.

Boundaries:
- pc=32'hFFFF_FFFC with no branch taken -> next_pc=0 (wrap). No trap.
- instret wraps from FFFF_FFFF to 0.
- branch and jump both high -> jump dominates; taken=1.

Decomposition:
- Package pc_seq_pkg:
  - state enum (FETCH, EXEC, HALT, TRAP)
  - trap cause enum: NONE=2'b00, MISALIGN=2'b01, TIMEOUT=2'b10, ILLEGAL=2'b11
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
- One combinational sub-module, branch_cond: inputs funct3, zero, lt, ltu; outputs cond and illegal.

Test Plan:
1. Sequential fetch: reset, then imem_ready every FETCH cycle with no branch -> pc visits 0,4,8,C on successive commits; instret=4 after four retirements.
2. BNE taken: pc=8, branch=1, funct3=001, zero=0, alu_result=0x40 -> next_pc_src=1, next_pc=0x40, pc=0x40 after commit. Same stimulus with zero=1 -> pc=0xC.
3. JALR with alu_result=0x101 -> target 0x100, commit; alu_result=0x102 -> TRAP, trap_cause=01, pc holds, imem_req stays 0 thereafter.
4. Fetch timeout, IMEM_TIMEOUT=16, imem_ready held low:
   - -> trap=1 and trap_cause=10 after 16 FETCH cycles.
   - imem_ready on cycle 16 instead -> EXEC, no trap.
5. In EXEC: stall=1 for 3 cycles together with halt_req=1 -> pc and instret hold for 3 cycles; then stall=0 -> HALT, halted=1, instret+1.
6. Reset mid-FETCH while imem_req=1 -> next cycle imem_req=0, pc=RESET_VEC, trap=0, halted=0, instret=0; fetching resumes at RESET_VEC.
